apb_req_arbiter: RTL and testbench
==================================

Name: apb_req_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single APB master bridge between NUM_REQ requester channels.
- Accepts one command (read/write, 9-bit address, 8-bit write data) from the winning requester.
- Drives the bridge's transfer/READ_WRITE/address/data inputs, watches PENABLE/PREADY for completion, and returns read data plus an error to that requester.
- Sits between the system requesters and the APB protocol top, with exactly one transfer outstanding at a time.

Parameters:
NUM_REQ, 2, number of requester channels (>=2)
ADDR_W, 9, APB address width (bit 8 selects slave2)
DATA_W, 8, APB data width
TIMEOUT, 16, max cycles in XFER before forced error completion (>=2)

Ports:
PCLK  input  1  clock, rising edge
PRESETn  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester command valid
req_write  input  NUM_REQ  1=write, 0=read, per requester
req_addr  input  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  input  NUM_REQ*DATA_W  packed write data
req_ready  output  NUM_REQ  one-hot one-cycle accept pulse
rsp_valid  output  NUM_REQ  one-hot one-cycle completion pulse
rsp_rdata  output  DATA_W  read data, valid with rsp_valid
rsp_err  output  1  error, valid with rsp_valid
transfer  output  1  to bridge transfer
READ_WRITE  output  1  to bridge, 1=read, 0=write
apb_write_paddr  output  ADDR_W  to bridge
apb_write_data  output  DATA_W  to bridge
apb_read_paddr  output  ADDR_W  to bridge
PENABLE  input  1  from bridge
PREADY  input  1  selected slave ready
PSLVERR  input  1  from bridge
apb_read_data_out  input  DATA_W  from bridge
busy  output  1  state != IDLE
grant_id  output  $clog2(NUM_REQ)  index of current or last grantee

Behaviour:
- Reset (async, PRESETn=0): every output 0, state IDLE, rr pointer 0, timeout counter 0, latched command 0. A reset mid-transfer aborts silently, with no rsp_valid.
- States: IDLE -> XFER -> RESP -> IDLE.
- IDLE: if any req_valid, grant the first set bit scanning from the pointer upward with wrap. In that cycle:
  - req_ready[g]=1 (combinational, one cycle).
  - Latch write, addr, wdata and g.
  - Next state XFER.
  - No req_valid: stay in IDLE.
- Requesters hold req_valid until req_ready. Later changes to the inputs are ignored, and other requests wait in IDLE.
- XFER:
  - transfer = 1 except in the completion cycle (PENABLE && PREADY), where it is combinationally 0. This prevents the bridge re-entering SETUP.
  - READ_WRITE = ~latched_write.
  - Write: apb_write_paddr = addr, apb_write_data = wdata, apb_read_paddr = 0.
  - Read: apb_read_paddr = addr, write fields = 0.
  - Timeout counter increments every XFER cycle.
- Completion (PENABLE && PREADY in XFER): latch err = PSLVERR, go to RESP, clear the counter.
- Timeout: counter reaches TIMEOUT-1 without completion. Then transfer is 0 that cycle, err = 1, read data is forced to 0, and the next state is RESP.
- RESP (one cycle):
  - transfer = 0.
  - rsp_valid[g] = 1.
  - rsp_rdata = apb_read_data_out sampled this cycle for a read, 0 for a write or timeout.
  - rsp_err = latched err.
  - Pointer becomes (g+1) mod NUM_REQ.
  - Next state IDLE.
- rsp_rdata and rsp_err are 0 whenever rsp_valid is all-zero.
- Latency: accept at cycle 0, XFER from cycle 1, minimum 2 XFER cycles for a zero-wait slave, RSP one cycle after completion. The next accept is no earlier than the cycle after RESP.
- Simultaneous requests: round-robin, so one requester cannot starve another. The pointer moves only on completion, including timeout.
- Slave decode (address bit 8) is not this block's concern; addresses pass through unchanged.
- Counter width is $clog2(TIMEOUT+1) and does not wrap; it is cleared on leaving XFER.

Decomposition:
- Package apb_arb_pkg:
  - state enum {IDLE, XFER, RESP}
  - RW encoding constants (RW_READ=1, RW_WRITE=0)
  - default ADDR_W/DATA_W
- Sub-module rr_arbiter: combinational one-hot grant from a request vector and a pointer, parameterised by NUM_REQ. Everything else lives in apb_req_arbiter.

Test Plan:
1. Req0 write, addr 9'h005, data 8'hA5, zero-wait slave1 -> req_ready[0] pulse; transfer=1, READ_WRITE=0, apb_write_paddr=9'h005; rsp_valid[0] with rsp_err=0 the cycle after PENABLE&&PREADY; transfer never high in RESP.
2. Req1 write 9'h105/8'h3C, then req1 read 9'h105 -> apb_read_paddr=9'h105, READ_WRITE=1, rsp_valid[1] with rsp_rdata=8'h3C.
3. req_valid=2'b11 held after reset for 4 transfers -> grant_id sequence 0,1,0,1; each rsp_valid bit matches its grant.
4. PREADY forced 0, TIMEOUT=16 -> rsp_valid pulses with rsp_err=1, rsp_rdata=0, exactly 16 cycles after XFER entry; next request is then served normally.
5. Slave returns PSLVERR=1 on completion -> rsp_err=1 for that response only; the following response has rsp_err=0.
6. PRESETn low during XFER -> transfer, busy, req_ready and rsp_valid go 0 immediately; no response emitted; after release, a pending req1 request is granted from pointer 0 order.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB requester arbiter: FSM states,
// READ_WRITE encoding and default bus widths.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping,
// returned both one-hot and as an index.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PW-1:0]      gnt_idx
);

  logic [PW-1:0] scan_idx;
  logic          found;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    scan_idx = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[scan_idx]) begin
        gnt[scan_idx] = 1'b1;
        gnt_idx       = scan_idx;
        found         = 1'b1;
      end
      scan_idx = (scan_idx == PW'(NUM_REQ - 1)) ? '0 : scan_idx + PW'(1);
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master bridge among NUM_REQ requesters: round-robin accept,
// single outstanding transfer, timeout guard, one-cycle response pulse.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int ADDR_W  = DEF_ADDR_W,
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int TIMEOUT = 16,
  localparam int PW      = $clog2(NUM_REQ)
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      transfer,
  output logic                      READ_WRITE,
  output logic [ADDR_W-1:0]         apb_write_paddr,
  output logic [DATA_W-1:0]         apb_write_data,
  output logic [ADDR_W-1:0]         apb_read_paddr,
  input  logic                      PENABLE,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  input  logic [DATA_W-1:0]         apb_read_data_out,
  output logic                      busy,
  output logic [PW-1:0]             grant_id
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t              state_q;
  logic [PW-1:0]       ptr_q;
  logic [PW-1:0]       gnt_q;
  logic [CW-1:0]       cnt_q;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                err_q;
  logic                to_q;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [PW-1:0]       arb_idx;
  logic                in_idle, in_xfer, in_resp;
  logic                complete, timeout;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // req_ready is combinational from req_valid, so it is also masked while
  // PRESETn is low to keep every output quiet during reset.
  assign in_idle  = (state_q == IDLE) && PRESETn;
  assign in_xfer  = (state_q == XFER);
  assign in_resp  = (state_q == RESP);
  assign complete = in_xfer && PENABLE && PREADY;
  assign timeout  = in_xfer && !complete && (cnt_q == CW'(TIMEOUT - 1));

  assign req_ready       = in_idle ? arb_gnt : '0;
  assign transfer        = in_xfer && !complete && !timeout;
  assign READ_WRITE      = in_xfer ? (wr_q ? RW_WRITE : RW_READ) : 1'b0;
  assign apb_write_paddr = (in_xfer && wr_q)  ? addr_q  : '0;
  assign apb_write_data  = (in_xfer && wr_q)  ? wdata_q : '0;
  assign apb_read_paddr  = (in_xfer && !wr_q) ? addr_q  : '0;

  always_comb begin
    rsp_valid = '0;
    if (in_resp) rsp_valid[gnt_q] = 1'b1;
  end

  assign rsp_rdata = (in_resp && !wr_q && !to_q) ? apb_read_data_out : '0;
  assign rsp_err   = in_resp && err_q;
  assign busy      = (state_q != IDLE);
  assign grant_id  = gnt_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            wr_q    <= req_write[arb_idx];
            addr_q  <= req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
            wdata_q <= req_wdata[int'(arb_idx)*DATA_W +: DATA_W];
            gnt_q   <= arb_idx;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (complete) begin
            err_q   <= PSLVERR;
            cnt_q   <= '0;
            state_q <= RESP;
          end else if (timeout) begin
            err_q   <= 1'b1;
            to_q    <= 1'b1;
            cnt_q   <= '0;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP: begin
          ptr_q   <= (gnt_q == PW'(NUM_REQ - 1)) ? '0 : gnt_q + PW'(1);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: the bench plays both requesters and the
// APB bridge, driving inputs on the falling edge and checking 1ns later.
module tb_apb_req_arbiter;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [17:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        transfer;
  logic        READ_WRITE;
  logic [8:0]  apb_write_paddr;
  logic [7:0]  apb_write_data;
  logic [8:0]  apb_read_paddr;
  logic        PENABLE;
  logic        PREADY;
  logic        PSLVERR;
  logic [7:0]  apb_read_data_out;
  logic        busy;
  logic [0:0]  grant_id;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 PCLK = ~PCLK;

  apb_req_arbiter #(.NUM_REQ(2), .ADDR_W(9), .DATA_W(8), .TIMEOUT(16)) dut (
    .PCLK              (PCLK),
    .PRESETn           (PRESETn),
    .req_valid         (req_valid),
    .req_write         (req_write),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .req_ready         (req_ready),
    .rsp_valid         (rsp_valid),
    .rsp_rdata         (rsp_rdata),
    .rsp_err           (rsp_err),
    .transfer          (transfer),
    .READ_WRITE        (READ_WRITE),
    .apb_write_paddr   (apb_write_paddr),
    .apb_write_data    (apb_write_data),
    .apb_read_paddr    (apb_read_paddr),
    .PENABLE           (PENABLE),
    .PREADY            (PREADY),
    .PSLVERR           (PSLVERR),
    .apb_read_data_out (apb_read_data_out),
    .busy              (busy),
    .grant_id          (grant_id)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transaction: accept, n_xfer XFER cycles (last one completes
  // unless to_mode, where PREADY never rises), then the RESP cycle.
  task automatic run_xfer(
    input string      name,
    input int         id,
    input logic       wr,
    input logic [8:0] addr,
    input logic [7:0] wd,
    input logic [1:0] valid,
    input logic [1:0] valid_after,
    input int         n_xfer,
    input logic       to_mode,
    input logic       slverr,
    input logic [7:0] rd_bus,
    input logic [1:0] exp_onehot,
    input logic       exp_gid,
    input logic [7:0] exp_rdata,
    input logic       exp_err
  );
    logic last;
    @(negedge PCLK);
    req_valid            = valid;
    req_write[id]        = wr;
    req_addr[id*9 +: 9]  = addr;
    req_wdata[id*8 +: 8] = wd;
    PENABLE = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
    apb_read_data_out = rd_bus;
    #1;
    check({name, " accept req_ready"}, req_ready, exp_onehot);
    check({name, " accept busy"}, busy, 1'b0);
    for (int k = 0; k < n_xfer; k++) begin
      last = (k == n_xfer - 1);
      @(negedge PCLK);
      req_valid = valid_after;
      PENABLE   = (k > 0);
      PREADY    = last && !to_mode;
      PSLVERR   = last && slverr;
      #1;
      if (k == 0) begin
        check({name, " grant_id"}, grant_id, exp_gid);
        check({name, " READ_WRITE"}, READ_WRITE, !wr);
        check({name, " write_paddr"}, apb_write_paddr, wr ? addr : 9'h000);
        check({name, " write_data"}, apb_write_data, wr ? wd : 8'h00);
        check({name, " read_paddr"}, apb_read_paddr, wr ? 9'h000 : addr);
      end
      check({name, " xfer transfer"}, transfer, !last);
      check({name, " xfer rsp_valid"}, rsp_valid, 2'b00);
      check({name, " xfer busy"}, busy, 1'b1);
      check({name, " xfer req_ready"}, req_ready, 2'b00);
    end
    @(negedge PCLK);
    PENABLE = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
    #1;
    check({name, " resp rsp_valid"}, rsp_valid, exp_onehot);
    check({name, " resp rsp_rdata"}, rsp_rdata, exp_rdata);
    check({name, " resp rsp_err"}, rsp_err, exp_err);
    check({name, " resp transfer"}, transfer, 1'b0);
    check({name, " resp req_ready"}, req_ready, 2'b00);
  endtask

  task automatic pulse_reset();
    @(negedge PCLK);
    PRESETn   = 1'b0;
    req_valid = 2'b00;
    @(posedge PCLK);
    #1 PRESETn = 1'b1;
  endtask

  initial begin
    PRESETn = 1'b0;
    req_valid = 2'b11; req_write = 2'b00; req_addr = '0; req_wdata = '0;
    PENABLE = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0; apb_read_data_out = 8'hC3;
    #12;
    // Reset state: everything quiet even with both requests raised.
    check("rst req_ready", req_ready, 2'b00);
    check("rst rsp_valid", rsp_valid, 2'b00);
    check("rst rsp_rdata", rsp_rdata, 8'h00);
    check("rst rsp_err", rsp_err, 1'b0);
    check("rst transfer", transfer, 1'b0);
    check("rst READ_WRITE", READ_WRITE, 1'b0);
    check("rst write_paddr", apb_write_paddr, 9'h000);
    check("rst read_paddr", apb_read_paddr, 9'h000);
    check("rst busy", busy, 1'b0);
    check("rst grant_id", grant_id, 1'b0);
    req_valid = 2'b00;
    @(posedge PCLK);
    #1 PRESETn = 1'b1;

    // 1: zero-wait write from req0.
    run_xfer("t1", 0, 1'b1, 9'h005, 8'hA5, 2'b01, 2'b00, 2, 1'b0, 1'b0, 8'hC3, 2'b01, 1'b0, 8'h00, 1'b0);
    @(negedge PCLK); #1;
    check("t1 idle rsp_valid", rsp_valid, 2'b00);
    check("t1 idle rsp_rdata", rsp_rdata, 8'h00);
    check("t1 idle busy", busy, 1'b0);

    // 2: req1 writes then reads back the same location.
    run_xfer("t2w", 1, 1'b1, 9'h105, 8'h3C, 2'b10, 2'b00, 2, 1'b0, 1'b0, 8'h00, 2'b10, 1'b1, 8'h00, 1'b0);
    run_xfer("t2r", 1, 1'b0, 9'h105, 8'h00, 2'b10, 2'b00, 2, 1'b0, 1'b0, 8'h3C, 2'b10, 1'b1, 8'h3C, 1'b0);

    // 3: both requesting continuously after reset -> 0,1,0,1.
    pulse_reset();
    req_write[1] = 1'b0; req_addr[17:9] = 9'h120;
    run_xfer("t3a", 0, 1'b1, 9'h010, 8'h11, 2'b11, 2'b11, 2, 1'b0, 1'b0, 8'h77, 2'b01, 1'b0, 8'h00, 1'b0);
    run_xfer("t3b", 1, 1'b0, 9'h120, 8'h00, 2'b11, 2'b11, 2, 1'b0, 1'b0, 8'h77, 2'b10, 1'b1, 8'h77, 1'b0);
    run_xfer("t3c", 0, 1'b1, 9'h010, 8'h11, 2'b11, 2'b11, 3, 1'b0, 1'b0, 8'h77, 2'b01, 1'b0, 8'h00, 1'b0);
    run_xfer("t3d", 1, 1'b0, 9'h120, 8'h00, 2'b11, 2'b00, 2, 1'b0, 1'b0, 8'h78, 2'b10, 1'b1, 8'h78, 1'b0);

    // 4: PREADY stuck low -> forced error after 16 XFER cycles, rdata 0.
    run_xfer("t4to", 0, 1'b0, 9'h033, 8'h00, 2'b01, 2'b00, 16, 1'b1, 1'b0, 8'hEE, 2'b01, 1'b0, 8'h00, 1'b1);
    run_xfer("t4ok", 1, 1'b0, 9'h044, 8'h00, 2'b10, 2'b00, 4, 1'b0, 1'b0, 8'h5A, 2'b10, 1'b1, 8'h5A, 1'b0);

    // 5: slave error on one response only.
    run_xfer("t5err", 0, 1'b1, 9'h1F0, 8'h99, 2'b01, 2'b00, 2, 1'b0, 1'b1, 8'h00, 2'b01, 1'b0, 8'h00, 1'b1);
    run_xfer("t5ok", 0, 1'b1, 9'h1F1, 8'h9A, 2'b01, 2'b00, 2, 1'b0, 1'b0, 8'h00, 2'b01, 1'b0, 8'h00, 1'b0);

    // 6: reset in the middle of a req1 transfer, with req1 pending again.
    @(negedge PCLK);
    req_valid = 2'b10; req_write[1] = 1'b1; req_addr[17:9] = 9'h0AA; req_wdata[15:8] = 8'h55;
    #1;
    check("t6 accept req_ready", req_ready, 2'b10);
    @(negedge PCLK);
    req_valid = 2'b00;
    #1;
    check("t6 xfer transfer", transfer, 1'b1);
    check("t6 xfer grant_id", grant_id, 1'b1);
    @(posedge PCLK);
    #2;
    req_valid = 2'b10;
    PRESETn   = 1'b0;
    #1;
    check("t6 rst transfer", transfer, 1'b0);
    check("t6 rst busy", busy, 1'b0);
    check("t6 rst req_ready", req_ready, 2'b00);
    check("t6 rst rsp_valid", rsp_valid, 2'b00);
    check("t6 rst grant_id", grant_id, 1'b0);
    check("t6 rst write_paddr", apb_write_paddr, 9'h000);
    @(posedge PCLK);
    #1 PRESETn = 1'b1;
    run_xfer("t6post", 1, 1'b1, 9'h0BB, 8'h66, 2'b10, 2'b00, 2, 1'b0, 1'b0, 8'h00, 2'b10, 1'b1, 8'h00, 1'b0);

    @(negedge PCLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
